// File: rtl/cnt163_sched.sv
// Two-requester round-robin scheduler for a shared 163-style loadable
// counter. The block grants the counter to one requester, loads the preset,
// lets the counter run until it wraps from all-ones, and then pulses done
// to the owner.
module cnt163_sched #(
  parameter int W = 4
) (
  input  logic         clk_50M,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [1:0]   req,
  input  logic [W-1:0] len0,
  input  logic [W-1:0] len1,
  input  logic         pause,
  input  logic [W-1:0] q,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic         busy,
  output logic         ld_n,
  output logic         ct_t,
  output logic         ct_p,
  output logic [W-1:0] d
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [W-1:0] TERM = '1;
  localparam logic [W-1:0] ONE  = W'(1);

  state_t       state;
  state_t       state_nx;
  logic         owner;
  logic         owner_nx;
  logic         ptr;
  logic         ptr_nx;
  logic [1:0]   gnt_nx;
  logic [1:0]   done_nx;
  logic         busy_nx;
  logic         ld_n_nx;
  logic         ct_t_nx;
  logic         ct_p_nx;
  logic [W-1:0] d_nx;

  logic         win;
  logic         owner_req;
  logic         abort;
  logic         expire;

  // The preset is the two's complement of the length: starting there, the
  // len-th increment wraps all-ones to zero. len=0 gives 0, i.e. 2^W ticks.
  function automatic logic [W-1:0] calc_preset(input logic [W-1:0] len);
    return (~len) + ONE;
  endfunction

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Winner of a fresh arbitration: a lone requester wins outright, a tie
  // goes to the requester the round-robin pointer favours.
  assign win       = (req == 2'b11) ? ptr : req[1];
  assign owner_req = owner ? req[1] : req[0];
  assign abort     = ~owner_req;
  // ct_p is the enable the counter actually sees this cycle, so a paused
  // tick can never be mistaken for the expiring one.
  assign expire    = tick & ct_p & (q == TERM);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    gnt_nx   = gnt;
    done_nx  = 2'b00;
    busy_nx  = busy;
    ld_n_nx  = ld_n;
    ct_t_nx  = ct_t;
    ct_p_nx  = ct_p;
    d_nx     = d;

    case (state)
      IDLE: begin
        gnt_nx  = 2'b00;
        busy_nx = 1'b0;
        ld_n_nx = 1'b1;
        ct_t_nx = 1'b0;
        ct_p_nx = 1'b0;
        if (req != 2'b00) begin
          owner_nx = win;
          gnt_nx   = onehot(win);
          busy_nx  = 1'b1;
          d_nx     = calc_preset(win ? len1 : len0);
          ld_n_nx  = 1'b0;
          state_nx = LOAD;
        end
      end

      LOAD: begin
        if (abort) begin
          gnt_nx   = 2'b00;
          busy_nx  = 1'b0;
          ld_n_nx  = 1'b1;
          ct_t_nx  = 1'b0;
          ct_p_nx  = 1'b0;
          ptr_nx   = ~owner;
          state_nx = IDLE;
        end else if (tick) begin
          // This tick loads the preset; counting starts with the next one.
          ld_n_nx  = 1'b1;
          ct_t_nx  = 1'b1;
          ct_p_nx  = ~pause;
          state_nx = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          // Abort wins over a simultaneous expiry: no done is issued.
          gnt_nx   = 2'b00;
          busy_nx  = 1'b0;
          ld_n_nx  = 1'b1;
          ct_t_nx  = 1'b0;
          ct_p_nx  = 1'b0;
          ptr_nx   = ~owner;
          state_nx = IDLE;
        end else if (expire) begin
          done_nx  = onehot(owner);
          ct_t_nx  = 1'b0;
          ct_p_nx  = 1'b0;
          state_nx = DONE;
        end else begin
          ct_t_nx  = 1'b1;
          ct_p_nx  = ~pause;
        end
      end

      DONE: begin
        // Release cycle: no grant is issued here, which enforces the
        // two-cycle gap and hands priority to the other requester.
        gnt_nx   = 2'b00;
        busy_nx  = 1'b0;
        ld_n_nx  = 1'b1;
        ct_t_nx  = 1'b0;
        ct_p_nx  = 1'b0;
        ptr_nx   = ~owner;
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, owner, pointer and output registers, cleared asynchronously.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      ptr   <= 1'b0;
      gnt   <= 2'b00;
      done  <= 2'b00;
      busy  <= 1'b0;
      ld_n  <= 1'b1;
      ct_t  <= 1'b0;
      ct_p  <= 1'b0;
      d     <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      ptr   <= ptr_nx;
      gnt   <= gnt_nx;
      done  <= done_nx;
      busy  <= busy_nx;
      ld_n  <= ld_n_nx;
      ct_t  <= ct_t_nx;
      ct_p  <= ct_p_nx;
      d     <= d_nx;
    end
  end

endmodule

// File: doc/cnt163_sched.md
# cnt163_sched

Two-requester scheduler for the shared 163-style 4-bit synchronous loadable counter. Each requester asks for a one-shot interval of `len` counter ticks. The block arbitrates round-robin and grants the counter to one requester. It then sequences the counter through preset-load and count phases by driving its LD/ct_t/ct_p/D controls, and returns a one-cycle `done` to the owner when the interval expires. It sits between the requesting control logic and the counter slice, which keeps its own prescaled tick.

## Interface
Parameters:
- W, 4, counter and length width; terminal count is all-ones (2^W − 1)

Ports:
- clk_50M  in  1  system clock, all flops on rising edge
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle strobe; counter acts (loads/increments) only in cycles with tick=1
- req  in  2  request per requester; held high until `done` or intentionally dropped (abort)
- len0, len1  in  W each  interval length per requester, sampled at grant; 0 means 2^W ticks
- pause  in  1  freezes counting of the current owner (drives ct_p low)
- q  in  W  counter output
- gnt  out  2  one-hot owner, zero when idle
- done  out  2  one-cycle pulse to the owner at interval expiry
- busy  out  1  high whenever gnt≠0
- ld_n  out  1  to counter LD: 0 = synchronous load, 1 = count mode
- ct_t, ct_p  out  1 each  counter enables; counting only when both are 1
- d  out  W  preset to counter D

## Operation
- All outputs registered. Reset values: gnt=00, done=00, busy=0, ld_n=1, ct_t=0, ct_p=0, d=0. Round-robin pointer resets to "requester 0 has priority". State resets to IDLE.
- Preset is P = 2^W − len, modulo 2^W (len=0 → P=0). Counter starts at P and increments. The Nth increment wraps it from all-ones to 0.
- IDLE:
  - ld_n=1, ct_t=ct_p=0.
  - If any req is high, grant one requester.
  - Single request: that requester is granted.
  - Both requesting: the pointer-favoured requester wins.
  - On grant: latch owner, set gnt/busy, d=P from the owner's len, ld_n=0, go to LOAD.
- LOAD: hold ld_n=0 and d. On tick the counter loads P. Next cycle: ld_n=1, ct_t=1, ct_p=~pause, go to RUN.
- RUN:
  - ct_t=1 and ct_p=~pause, updated every cycle.
  - Expiry occurs on tick & ct_p & (q == all-ones). It is registered: next cycle done[owner]=1 for one cycle, ct_t=ct_p=0, go to DONE.
  - Ticks while paused do not count and cannot cause expiry.
- DONE:
  - Clear done, gnt and busy.
  - Point the round-robin pointer at the non-owner.
  - Go to IDLE. No new grant is issued in this cycle.
- Abort: if req[owner] falls in LOAD or RUN, the next cycle clears gnt/busy, sets ld_n=1 and ct_t=ct_p=0, updates the pointer as in DONE, goes to IDLE, and issues no done.
- Abort has priority over expiry when both occur in the same cycle.
- len changes after grant are ignored. A change on the non-owner's lines affects only its future grant.

## Timing
- Grant latency: req high in IDLE → gnt high the next edge.
- Load: first tick after entering LOAD. Count: the N ticks that follow, excluding paused ticks.
- done pulse: exactly one clk_50M cycle, one edge after the expiring tick. gnt falls one edge after done.
- Minimum gap between consecutive grants: 2 cycles (DONE, then IDLE).
- A requester holding req after its done is re-granted only if the other requester is not requesting. This guarantees no starvation.
- tick on the same cycle as entering LOAD is not seen. The load uses the next tick.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). The counter stops counting because ct_t=0.

## Test plan
- Single request, len0=3, tick every 2 cycles: gnt=01, d=4'hD, ld_n=0 for one tick. The counter then steps D→E→F→0 and done[0] pulses once after the third counted tick. busy low two cycles after done.
- Both request together, len0=len1=1: requester 0 is served first (P=F, done after 1 counted tick). Then requester 1 is served. With both held, grants alternate 01,10,01.
- len1=0: d=0, done[1] after exactly 16 counted ticks.
- pause high for 5 ticks mid-RUN, len0=4: ct_p=0 during pause, q frozen, done delayed by exactly the paused ticks.
- req0 dropped during RUN at q=E: no done, gnt=00, ct_t=ct_p=0, pointer favours requester 1.
- rst_n pulsed low during RUN: all outputs at reset values asynchronously. After release, a new req is granted from IDLE with requester 0 priority.
